ahb_burst_busfsm: RTL

//  AHB-Lite controller for one bus requester (IFU or LSU); successor to the single-beat NON_SEQ controller.

---
 rtl/ebu_pkg.sv | 35 +++
 rtl/busfsm_beatcounter.sv | 23 ++
 rtl/ahb_burst_busfsm.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ebu_pkg.sv
// Shared types and AHB encodings for the external bus unit controllers.
package ebu_pkg;

    typedef enum logic [2:0] {
        ADR_PHASE,
        DATA_PHASE,
        MEM3,
        CACHE_WRITEBACK,
        CACHE_FETCH
    } busstate_t;

    typedef enum logic [1:0] {
        AHB_IDLE   = 2'b00,
        AHB_BUSY   = 2'b01,
        AHB_NONSEQ = 2'b10,
        AHB_SEQ    = 2'b11
    } ahbtranstype_t;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // Fixed-length INCR code for a line of the given beat count, open INCR otherwise.
    function automatic logic [2:0] burst_code(input int unsigned beats);
        case (beats)
            32'd4:   return HBURST_INCR4;
            32'd8:   return HBURST_INCR8;
            32'd16:  return HBURST_INCR16;
            default: return HBURST_INCR;
        endcase
    endfunction

endpackage

// File: rtl/busfsm_beatcounter.sv
// Beat index counter: clear wins over enable, holds at MAXVAL instead of wrapping.
module busfsm_beatcounter #(
    parameter int unsigned BEATW  = 2,
    parameter int unsigned MAXVAL = 3
) (
    input  logic             HCLK,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [BEATW-1:0] cnt
);

    localparam logic [BEATW-1:0] CNT_MAX = BEATW'(MAXVAL);

    always_ff @(posedge HCLK) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + BEATW'(1);
        end
    end

endmodule

// File: rtl/ahb_burst_busfsm.sv
// AHB-Lite requester controller: uncached single transfers plus cache-line INCR bursts.
module ahb_burst_busfsm
    import ebu_pkg::*;
#(
    parameter  int unsigned BEATSPERLINE = 4,
    localparam int unsigned BEATW        = $clog2(BEATSPERLINE)
) (
    input  logic             HCLK,
    input  logic             reset,
    input  logic             Stall,
    input  logic             Flush,
    input  logic [1:0]       BusRW,
    input  logic [1:0]       CacheBusRW,
    input  logic             HREADY,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HBURST,
    output logic [BEATW-1:0] BeatCount,
    output logic [BEATW-1:0] BeatCountDelayed,
    output logic             CaptureEn,
    output logic             CacheBusAck,
    output logic             BusStall,
    output logic             BusCommitted
);

    localparam logic [BEATW-1:0] LAST_BEAT  = BEATW'(BEATSPERLINE - 1);
    localparam logic [2:0]       LINE_BURST = burst_code(BEATSPERLINE);

    busstate_t        state, next_state;
    ahbtranstype_t    htrans_c;
    logic [BEATW-1:0] adr_cnt, data_cnt;
    logic             adr_done;
    logic             in_cache, cache_req, any_req;
    logic             adr_en, data_en, final_beat;

    assign in_cache   = (state == CACHE_WRITEBACK) || (state == CACHE_FETCH);
    assign cache_req  = |CacheBusRW;
    assign any_req    = cache_req || (|BusRW);
    // Address beats are counted only for line transfers; single transfers leave the index at 0.
    assign adr_en     = (htrans_c != AHB_IDLE) && HREADY
                        && (in_cache || ((state == ADR_PHASE) && cache_req));
    assign data_en    = in_cache && HREADY;
    assign final_beat = data_en && (data_cnt == LAST_BEAT);

    busfsm_beatcounter #(.BEATW(BEATW), .MAXVAL(BEATSPERLINE - 1)) u_adr_cnt (
        .HCLK  (HCLK),
        .reset (reset),
        .en    (adr_en),
        .clr   (final_beat),
        .cnt   (adr_cnt)
    );

    busfsm_beatcounter #(.BEATW(BEATW), .MAXVAL(BEATSPERLINE - 1)) u_data_cnt (
        .HCLK  (HCLK),
        .reset (reset),
        .en    (data_en),
        .clr   (final_beat),
        .cnt   (data_cnt)
    );

    always_ff @(posedge HCLK) begin
        if (reset) begin
            state <= ADR_PHASE;
        end else begin
            state <= next_state;
        end
    end

    // Set once the last line address is accepted; stops further SEQ beats.
    always_ff @(posedge HCLK) begin
        if (reset || final_beat) begin
            adr_done <= 1'b0;
        end else if (adr_en && (adr_cnt == LAST_BEAT)) begin
            adr_done <= 1'b1;
        end
    end

    always_comb begin
        next_state  = state;
        htrans_c    = AHB_IDLE;
        HWRITE      = BusRW[0];
        HBURST      = HBURST_SINGLE;
        CaptureEn   = 1'b0;
        CacheBusAck = 1'b0;
        BusStall    = 1'b0;
        case (state)
            ADR_PHASE: begin
                BusStall = any_req;
                if (cache_req) begin
                    HWRITE = CacheBusRW[0];
                    HBURST = LINE_BURST;
                end
                if (HREADY && !Flush && any_req) begin
                    htrans_c = AHB_NONSEQ;
                    if (CacheBusRW[0])      next_state = CACHE_WRITEBACK;
                    else if (CacheBusRW[1]) next_state = CACHE_FETCH;
                    else                    next_state = DATA_PHASE;
                end
            end
            DATA_PHASE: begin
                CaptureEn = 1'b1;
                BusStall  = 1'b1;
                if (HREADY) next_state = MEM3;
            end
            MEM3: begin
                if (!Stall) next_state = ADR_PHASE;
            end
            CACHE_WRITEBACK, CACHE_FETCH: begin
                // Direction comes from the state so it stays fixed for the whole burst.
                HWRITE    = (state == CACHE_WRITEBACK);
                HBURST    = LINE_BURST;
                BusStall  = 1'b1;
                htrans_c  = adr_done ? AHB_IDLE : AHB_SEQ;
                CaptureEn = (state == CACHE_FETCH) && HREADY;
                if (final_beat) begin
                    CacheBusAck = 1'b1;
                    next_state  = MEM3;
                end
            end
            default: next_state = ADR_PHASE;
        endcase
    end

    assign HTRANS           = htrans_c;
    assign BeatCount        = adr_cnt;
    assign BeatCountDelayed = data_cnt;
    assign BusCommitted     = (state != ADR_PHASE);

endmodule
